// File: rtl/div_unit.sv
// ============================================================================
// Module   : div_unit
// Purpose  : Iterative radix-2 restoring divider for DIV/DIVU, fixed 33-cycle
//            stall, with sign fix-up, exception abort and hold-in-DONE.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module div_unit (
   input  logic        clk,
   input  logic        rst,
   input  logic        E_div_valid,
   input  logic        E_div_signed,
   input  logic [31:0] E_src_a,
   input  logic [31:0] E_src_b,
   input  logic        E_ena,
   input  logic        M_except,
   output logic        E_div_stall,
   output logic [31:0] div_lo,
   output logic [31:0] div_hi,
   output logic        div_done
);

   typedef enum logic [1:0] {
      S_IDLE = 2'd0,
      S_BUSY = 2'd1,
      S_DONE = 2'd2
   } state_t;

   state_t      r_state;
   logic [4:0]  r_cnt;
   logic [31:0] r_rem;
   logic [31:0] r_quo;
   logic [31:0] r_dvsr;
   logic        r_qsign;
   logic        r_rsign;
   logic        r_bzero;

   logic        w_start;
   logic [31:0] w_abs_a;
   logic [31:0] w_abs_b;
   logic [32:0] w_shift;
   logic [32:0] w_diff;
   logic        w_fit;
   logic [31:0] w_rem_nxt;
   logic [31:0] w_quo_nxt;
   logic [31:0] w_lo_fix;
   logic [31:0] w_hi_fix;

   assign w_start     = (r_state == S_IDLE) & E_div_valid & ~M_except;
   assign E_div_stall = ~rst & (w_start | (r_state == S_BUSY));

   assign w_abs_a = (E_div_signed & E_src_a[31]) ? -E_src_a : E_src_a;
   assign w_abs_b = (E_div_signed & E_src_b[31]) ? -E_src_b : E_src_b;

   // Quotient register doubles as the dividend shift source: its MSB feeds
   // the remainder while quotient bits enter at the LSB.
   assign w_shift   = {r_rem, r_quo[31]};
   assign w_diff    = w_shift - {1'b0, r_dvsr};
   assign w_fit     = ~w_diff[32];
   assign w_rem_nxt = w_fit ? w_diff[31:0] : w_shift[31:0];
   assign w_quo_nxt = {r_quo[30:0], w_fit};

   // A zero divisor leaves q all ones and r = |a|; negating r restores a.
   assign w_lo_fix = (r_qsign & ~r_bzero) ? -w_quo_nxt : w_quo_nxt;
   assign w_hi_fix = r_rsign ? -w_rem_nxt : w_rem_nxt;

   always_ff @(posedge clk) begin
      if (rst) begin
         r_state  <= S_IDLE;
         r_cnt    <= 5'd0;
         r_rem    <= 32'd0;
         r_quo    <= 32'd0;
         r_dvsr   <= 32'd0;
         r_qsign  <= 1'b0;
         r_rsign  <= 1'b0;
         r_bzero  <= 1'b0;
         div_lo   <= 32'd0;
         div_hi   <= 32'd0;
         div_done <= 1'b0;
      end else if (M_except) begin
         r_state  <= S_IDLE;
         r_cnt    <= 5'd0;
         div_done <= 1'b0;
      end else begin
         case (r_state)
            S_IDLE: begin
               if (E_div_valid) begin
                  r_rem   <= 32'd0;
                  r_quo   <= w_abs_a;
                  r_dvsr  <= w_abs_b;
                  r_qsign <= E_div_signed & (E_src_a[31] ^ E_src_b[31]);
                  r_rsign <= E_div_signed & E_src_a[31];
                  r_bzero <= (E_src_b == 32'd0);
                  r_cnt   <= 5'd0;
                  r_state <= S_BUSY;
               end
            end
            S_BUSY: begin
               r_rem <= w_rem_nxt;
               r_quo <= w_quo_nxt;
               r_cnt <= r_cnt + 5'd1;
               if (r_cnt == 5'd31) begin
                  div_lo   <= w_lo_fix;
                  div_hi   <= w_hi_fix;
                  div_done <= 1'b1;
                  r_state  <= S_DONE;
               end
            end
            S_DONE: begin
               if (E_ena) begin
                  div_done <= 1'b0;
                  r_state  <= S_IDLE;
               end
            end
            default: begin
               div_done <= 1'b0;
               r_state  <= S_IDLE;
            end
         endcase
      end
   end

endmodule

`default_nettype wire

// File: tb/tb_div_unit.sv
// ============================================================================
// Module   : tb_div_unit
// Purpose  : Self-checking bench for div_unit: vector table, corner sequences
//            and randomized operations against an arithmetic reference model.
// Revision : 1.0  initial release
// ============================================================================
`default_nettype none

module tb_div_unit;

   logic        clk;
   logic        rst;
   logic        E_div_valid;
   logic        E_div_signed;
   logic [31:0] E_src_a;
   logic [31:0] E_src_b;
   logic        E_ena;
   logic        M_except;
   logic        E_div_stall;
   logic [31:0] div_lo;
   logic [31:0] div_hi;
   logic        div_done;

   int n_checks;
   int n_errors;

   div_unit dut (
      .clk          (clk),
      .rst          (rst),
      .E_div_valid  (E_div_valid),
      .E_div_signed (E_div_signed),
      .E_src_a      (E_src_a),
      .E_src_b      (E_src_b),
      .E_ena        (E_ena),
      .M_except     (M_except),
      .E_div_stall  (E_div_stall),
      .div_lo       (div_lo),
      .div_hi       (div_hi),
      .div_done     (div_done)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   typedef struct {
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] lo;
      logic [31:0] hi;
   } vec_t;

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
      end
   endtask

   // Reference: plain language-level division with the ISA corner rules.
   task automatic model(input logic sgn, input logic [31:0] a, input logic [31:0] b,
                        output logic [31:0] lo, output logic [31:0] hi);
      if (b == 32'd0) begin
         lo = 32'hFFFF_FFFF;
         hi = a;
      end else if (sgn && a == 32'h8000_0000 && b == 32'hFFFF_FFFF) begin
         lo = 32'h8000_0000;
         hi = 32'd0;
      end else if (sgn) begin
         lo = $signed(a) / $signed(b);
         hi = $signed(a) % $signed(b);
      end else begin
         lo = a / b;
         hi = a % b;
      end
   endtask

   task automatic start_op(input logic sgn, input logic [31:0] a, input logic [31:0] b);
      @(negedge clk);
      E_div_valid  = 1'b1;
      E_div_signed = sgn;
      E_src_a      = a;
      E_src_b      = b;
      #1;
   endtask

   task automatic wait_done(output int n);
      n = 0;
      while (E_div_stall && n < 100) begin
         n++;
         @(negedge clk);
         #1;
      end
   endtask

   task automatic finish_op(input string name, input logic [31:0] elo, input logic [31:0] ehi);
      int n;
      wait_done(n);
      check({name, " latency"}, n, 33);
      check({name, " done"}, {31'd0, div_done}, 32'd1);
      check({name, " lo"}, div_lo, elo);
      check({name, " hi"}, div_hi, ehi);
      E_div_valid = 1'b0;
      @(negedge clk);
      #1;
      check({name, " done_clear"}, {31'd0, div_done}, 32'd0);
      check({name, " idle_stall"}, {31'd0, E_div_stall}, 32'd0);
   endtask

   vec_t vecs[10];

   initial begin
      int          n;
      logic        seen;
      logic        sgn;
      logic [31:0] a;
      logic [31:0] b;
      logic [31:0] elo;
      logic [31:0] ehi;

      n_checks = 0;
      n_errors = 0;

      vecs[0] = '{1'b0, 32'd100,        32'd7,          32'd14,         32'd2};
      vecs[1] = '{1'b1, 32'hFFFF_FFF9,  32'd2,          32'hFFFF_FFFD,  32'hFFFF_FFFF};
      vecs[2] = '{1'b1, 32'h8000_0000,  32'hFFFF_FFFF,  32'h8000_0000,  32'd0};
      vecs[3] = '{1'b0, 32'h1234_5678,  32'd0,          32'hFFFF_FFFF,  32'h1234_5678};
      vecs[4] = '{1'b1, 32'hFFFF_FFF0,  32'd0,          32'hFFFF_FFFF,  32'hFFFF_FFF0};
      vecs[5] = '{1'b1, 32'd7,          32'hFFFF_FFFE,  32'hFFFF_FFFD,  32'd1};
      vecs[6] = '{1'b0, 32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0};
      vecs[7] = '{1'b0, 32'd5,          32'd10,         32'd0,          32'd5};
      vecs[8] = '{1'b1, 32'h8000_0000,  32'd0,          32'hFFFF_FFFF,  32'h8000_0000};
      vecs[9] = '{1'b0, 32'hFFFF_FFF9,  32'd2,          32'h7FFF_FFFC,  32'd1};

      rst          = 1'b1;
      E_div_valid  = 1'b1;
      E_div_signed = 1'b0;
      E_src_a      = 32'd0;
      E_src_b      = 32'd0;
      E_ena        = 1'b1;
      M_except     = 1'b0;
      repeat (2) @(negedge clk);
      #1;
      check("reset stall", {31'd0, E_div_stall}, 32'd0);
      check("reset lo", div_lo, 32'd0);
      check("reset hi", div_hi, 32'd0);
      check("reset done", {31'd0, div_done}, 32'd0);
      E_div_valid = 1'b0;
      rst         = 1'b0;

      for (int i = 0; i < 10; i++) begin
         start_op(vecs[i].sgn, vecs[i].a, vecs[i].b);
         finish_op($sformatf("vec%0d", i), vecs[i].lo, vecs[i].hi);
      end

      // Exception during BUSY: stall drops one cycle later, nothing completes.
      start_op(1'b0, 32'd1000, 32'd3);
      repeat (10) begin
         @(negedge clk);
         #1;
      end
      M_except    = 1'b1;
      E_div_valid = 1'b0;
      #1;
      check("exc busy stall_same", {31'd0, E_div_stall}, 32'd1);
      @(negedge clk);
      M_except = 1'b0;
      #1;
      check("exc busy stall_next", {31'd0, E_div_stall}, 32'd0);
      check("exc busy done", {31'd0, div_done}, 32'd0);
      seen = 1'b0;
      repeat (40) begin
         @(negedge clk);
         #1;
         if (div_done || E_div_stall) seen = 1'b1;
      end
      check("exc busy no_activity", {31'd0, seen}, 32'd0);
      start_op(1'b0, 32'd9, 32'd3);
      finish_op("after_exc 9/3", 32'd3, 32'd0);

      // Exception in IDLE masks the start in the same cycle.
      @(negedge clk);
      E_div_valid = 1'b1;
      M_except    = 1'b1;
      #1;
      check("exc idle stall", {31'd0, E_div_stall}, 32'd0);
      @(negedge clk);
      E_div_valid = 1'b0;
      M_except    = 1'b0;
      #1;
      check("exc idle no_start", {31'd0, E_div_stall}, 32'd0);

      // Hold in DONE while the E stage is frozen.
      E_ena = 1'b0;
      start_op(1'b0, 32'd50, 32'd5);
      wait_done(n);
      check("hold latency", n, 33);
      for (int k = 0; k < 4; k++) begin
         check($sformatf("hold done c%0d", k), {31'd0, div_done}, 32'd1);
         check($sformatf("hold stall c%0d", k), {31'd0, E_div_stall}, 32'd0);
         check($sformatf("hold lo c%0d", k), div_lo, 32'd10);
         check($sformatf("hold hi c%0d", k), div_hi, 32'd0);
         if (k == 3) begin
            E_ena       = 1'b1;
            E_div_valid = 1'b0;
         end
         @(negedge clk);
         #1;
      end
      check("hold released done", {31'd0, div_done}, 32'd0);
      check("hold released stall", {31'd0, E_div_stall}, 32'd0);
      @(negedge clk);
      #1;
      check("hold no_restart", {31'd0, div_done | E_div_stall}, 32'd0);

      // Reset mid-BUSY, then a fresh operation with valid kept high.
      start_op(1'b0, 32'hDEAD_BEEF, 32'd3);
      repeat (20) begin
         @(negedge clk);
         #1;
      end
      rst = 1'b1;
      #1;
      check("rst busy stall", {31'd0, E_div_stall}, 32'd0);
      @(negedge clk);
      #1;
      check("rst busy lo", div_lo, 32'd0);
      check("rst busy hi", div_hi, 32'd0);
      check("rst busy done", {31'd0, div_done}, 32'd0);
      E_src_a = 32'd1000;
      E_src_b = 32'd10;
      rst     = 1'b0;
      #1;
      finish_op("post_rst 1000/10", 32'd100, 32'd0);

      // Randomized operations against the reference model.
      for (int r = 0; r < 40; r++) begin
         sgn = 1'($urandom_range(0, 1));
         a   = $urandom;
         case ($urandom_range(0, 7))
            0:       b = 32'd0;
            1:       b = 32'd1;
            2:       b = 32'hFFFF_FFFF;
            3:       b = $urandom_range(1, 15);
            default: b = $urandom;
         endcase
         if ($urandom_range(0, 7) == 0) a = 32'h8000_0000;
         model(sgn, a, b, elo, ehi);
         start_op(sgn, a, b);
         finish_op($sformatf("rnd%0d s%0d %08h/%08h", r, sgn, a, b), elo, ehi);
      end

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule

`default_nettype wire

// File: doc/div_unit.md
DIV_UNIT -- requirements
Module: div_unit

Interface
REQ-001 SHALL provide `clk`, input, 1, the single clock; all state updates on its rising edge.
REQ-002 SHALL provide `rst`, input, 1, synchronous active-high reset.
REQ-003 SHALL provide `E_div_valid`, input, 1, a DIV or DIVU instruction occupies the E stage.
REQ-004 SHALL provide `E_div_signed`, input, 1: 1 = DIV (signed), 0 = DIVU (unsigned).
REQ-005 SHALL provide `E_src_a`, input, 32, dividend, sampled only at operation start.
REQ-006 SHALL provide `E_src_b`, input, 32, divisor, sampled only at operation start.
REQ-007 SHALL provide `E_ena`, input, 1, E-stage advance enable from the hazard unit.
REQ-008 SHALL provide `M_except`, input, 1, exception in M; aborts any divide.
REQ-009 SHALL provide `E_div_stall`, output, 1, stall request to the hazard unit.
REQ-010 SHALL provide `div_lo`, output, 32, quotient.
REQ-011 SHALL provide `div_hi`, output, 32, remainder.
REQ-012 SHALL provide `div_done`, output, 1, `div_lo`/`div_hi` valid for the E-stage instruction.

Function
REQ-013 SHALL implement FSM states IDLE, BUSY, DONE.
REQ-014 Start condition: IDLE & `E_div_valid` & ~`M_except`.
- SHALL latch |a|, |b| (signed) or raw a, b (unsigned).
- SHALL latch the quotient sign (a[31]^b[31]) and remainder sign (a[31]), both forced 0 when unsigned.
- SHALL clear the iteration counter and go to BUSY.
REQ-015 BUSY SHALL perform one radix-2 restoring step per cycle (shift remainder left, trial subtract, set quotient bit) for exactly 32 cycles, counter 0..31, then go to DONE.
REQ-016 Latency: start in cycle T, BUSY for T+1..T+32, DONE from T+33; fixed regardless of operand values.
REQ-017 `E_div_stall` SHALL equal (IDLE & `E_div_valid` & ~`M_except`) | BUSY, combinationally.
- Asserted in T and held through T+32 (33 cycles total).
- Low in DONE.
REQ-018 On DONE entry, SHALL apply sign fix-up:
- lo = quotient sign ? -q : q;
- hi = remainder sign ? -r : r;
- lo/hi are 32-bit two's-complement and wrap.
REQ-019 Signed 0x80000000 / 0xFFFFFFFF SHALL yield lo=0x80000000, hi=0 (wrap, no trap).
REQ-020 Divisor 0: no special path; SHALL yield lo=0xFFFFFFFF, hi=E_src_a for both DIV and DIVU; sign fix-up suppressed.
REQ-021 DONE SHALL hold `div_lo`/`div_hi`/`div_done`=1 while `E_ena`=0, and go to IDLE the cycle after `E_ena`=1.
REQ-022 The DONE state SHALL prevent re-starting the same instruction; a new start requires passing through IDLE.
REQ-023 `M_except`=1 in any state SHALL force IDLE next cycle, clear `div_done`, and discard partial results; `E_div_stall` SHALL drop in the same cycle `M_except` is seen in IDLE, and the next cycle in BUSY.
REQ-024 `E_src_a`/`E_src_b` changes during BUSY/DONE SHALL have no effect.
REQ-025 `div_done` SHALL be 1 only in DONE; `div_lo`/`div_hi` SHALL be undefined-but-stable elsewhere (registered, last value retained).

Reset
REQ-026 `rst`=1 SHALL set state=IDLE, counter=0, `div_lo`=0, `div_hi`=0, `div_done`=0, all operand/sign registers 0.
REQ-027 `E_div_stall` SHALL be 0 during reset regardless of `E_div_valid`.
REQ-028 Reset asserted mid-BUSY or in DONE SHALL abort the operation; the first post-reset cycle SHALL behave as IDLE.

Verification
REQ-029 DIVU 100/7, `E_ena`=1 at done -> stall exactly 33 cycles, then lo=14, hi=2, `div_done`=1 for one cycle, IDLE next.
REQ-030 DIV 0xFFFFFFF9/2 (-7/2) -> lo=0xFFFFFFFD, hi=0xFFFFFFFF; DIV 0x80000000/0xFFFFFFFF -> lo=0x80000000, hi=0.
REQ-031 DIVU 0x12345678/0 and DIV 0xFFFFFFF0/0 -> lo=0xFFFFFFFF, hi=operand a unchanged, latency still 33.
REQ-032 Start DIVU, assert `M_except` at BUSY cycle 10 -> IDLE next cycle, stall low, `div_done` never asserted; a new DIVU 9/3 afterward -> lo=3, hi=0.
REQ-033 Complete DIVU 50/5 with `E_ena`=0 for 3 cycles after DONE -> lo=10, hi=0, `div_done`=1 held 4 cycles, `E_div_stall`=0 throughout, single IDLE return, no restart.
REQ-034 `rst` pulse at BUSY cycle 20 -> all outputs 0 next cycle; `E_div_valid` held high -> fresh 33-cycle operation starts.
